// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit sides.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clock cycles per bit period (integer division, truncating).
  function automatic int baud_div(input int clkrate, input int baudrate);
    return clkrate / baudrate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer for a single asynchronous input.
// RST_VAL sets the value both flops take during reset (idle level of the line).
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  // Two-stage capture; the first stage may go metastable, the second settles it.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronizes the RX pin, validates the start bit at
// mid-bit, shifts in eight data bits LSB first and checks the stop bit.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for the synchronized line to go low
// START     | counting to mid start bit; a high sample there is a glitch
// DATA      | sampling one data bit every full bit period
// STOP      | sampling the stop bit; high -> byte out, low -> framing error
// WAIT_IDLE | after a framing error, wait for the line to return high
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int BAUDRATE = 9600,
  parameter int CLKRATE  = 25000000
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_rx,
  output logic [UART_DATA_BITS-1:0] o_rxbyte,
  output logic                      o_rxvalid,
  output logic                      o_framing_err,
  output logic                      o_busy
);

  localparam int BAUD_DIV = baud_div(CLKRATE, BAUDRATE);
  localparam int HALF     = BAUD_DIV / 2;
  localparam int BW       = $clog2(BAUD_DIV);

  localparam logic [BW-1:0] C_HALF_M1 = BW'(HALF - 1);
  localparam logic [BW-1:0] C_FULL_M1 = BW'(BAUD_DIV - 1);
  localparam logic [2:0]    C_LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_t r_state;
  rx_state_t w_state_nxt;

  logic                      w_rx_s;
  logic [BW-1:0]             r_baud_cnt;
  logic [2:0]                r_bit_cnt;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rxbyte;
  logic                      r_rxvalid;
  logic                      r_framing_err;

  logic w_baud_clr;
  logic w_bit_clr;
  logic w_bit_inc;
  logic w_shift_en;
  logic w_load_byte;
  logic w_ferr;

  uart_sync2 #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_rx),
    .o_q     (w_rx_s)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and datapath control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_clr  = 1'b0;
    w_bit_clr   = 1'b0;
    w_bit_inc   = 1'b0;
    w_shift_en  = 1'b0;
    w_load_byte = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_baud_clr  = 1'b1;
        end
      end
      START: begin
        if (r_baud_cnt == C_HALF_M1) begin
          w_baud_clr = 1'b1;
          if (!w_rx_s) begin
            w_state_nxt = DATA;
            w_bit_clr   = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (r_baud_cnt == C_FULL_M1) begin
          w_baud_clr = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_cnt == C_LAST_BIT) begin
            w_state_nxt = STOP;
          end else begin
            w_bit_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (r_baud_cnt == C_FULL_M1) begin
          w_baud_clr = 1'b1;
          if (w_rx_s) begin
            w_load_byte = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_rx_s) begin
          w_state_nxt = IDLE;
          w_baud_clr  = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_baud_clr  = 1'b1;
      end
    endcase
  end

  // Bit-period counter; parked at zero while the line is not being timed.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_baud_cnt <= '0;
    end else if (w_baud_clr || r_state == IDLE || r_state == WAIT_IDLE) begin
      r_baud_cnt <= '0;
    end else begin
      r_baud_cnt <= r_baud_cnt + 1'b1;
    end
  end

  // Data bit index and LSB-first shift register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (w_bit_clr) begin
        r_bit_cnt <= '0;
      end else if (w_bit_inc) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_shift_en) begin
        r_shift[r_bit_cnt] <= w_rx_s;
      end
    end
  end

  // Registered outputs: byte holds between frames, strobes last one cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rxbyte      <= '0;
      r_rxvalid     <= 1'b0;
      r_framing_err <= 1'b0;
    end else begin
      r_rxvalid     <= w_load_byte;
      r_framing_err <= w_ferr;
      if (w_load_byte) begin
        r_rxbyte <= r_shift;
      end
    end
  end

  assign o_rxbyte      = r_rxbyte;
  assign o_rxvalid     = r_rxvalid;
  assign o_framing_err = r_framing_err;
  assign o_busy        = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1 at BAUD_DIV = 16 (CLKRATE 160, BAUDRATE 10).
// Strobes are timestamped by a monitor; expected timestamps and bytes come
// from the frame timing rules applied to the cycle at which the start edge
// is first captured.
module tb_uart_rx_8n1;

  localparam int BD   = 16;
  localparam int HF   = BD / 2;
  localparam int LAT  = 2 + HF + 9 * BD;

  logic       clk;
  logic       i_rst_n;
  logic       i_rx;
  logic [7:0] o_rxbyte;
  logic       o_rxvalid;
  logic       o_framing_err;
  logic       o_busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  int         q_vt[$];
  logic [7:0] q_vb[$];
  int         q_ft[$];
  logic       both_seen = 1'b0;

  uart_rx_8n1 #(
    .BAUDRATE (10),
    .CLKRATE  (160)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (i_rst_n),
    .i_rx          (i_rx),
    .o_rxbyte      (o_rxbyte),
    .o_rxvalid     (o_rxvalid),
    .o_framing_err (o_framing_err),
    .o_busy        (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedge counter used as the timebase for strobe timestamps.
  always @(posedge clk) cyc <= cyc + 1;

  // Record every strobe cycle away from the active edge.
  always @(negedge clk) begin
    if (o_rxvalid) begin
      q_vt.push_back(cyc);
      q_vb.push_back(o_rxbyte);
    end
    if (o_framing_err) q_ft.push_back(cyc);
    if (o_rxvalid && o_framing_err) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_q();
    q_vt.delete();
    q_vb.delete();
    q_ft.delete();
  endtask

  // Caller is at a negedge; drives a whole frame, returns the capture edge E.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int e);
    i_rx = 1'b0;
    e = cyc + 1;
    repeat (BD) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      i_rx = b[k];
      repeat (BD) @(negedge clk);
    end
    i_rx = stop;
    repeat (BD) @(negedge clk);
  endtask

  task automatic idle(input int n);
    i_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int         e, e2;
    int         exp_vt[$];
    logic [7:0] exp_vb[$];
    int         exp_ft[$];
    logic [7:0] b;
    logic       stp;
    int         gap;
    int         nmin;

    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    @(negedge clk);
    chk("rst_rxbyte", o_rxbyte, 8'h00);
    chk("rst_rxvalid", o_rxvalid, 1'b0);
    chk("rst_ferr", o_framing_err, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    @(negedge clk);
    i_rst_n = 1'b1;
    idle(5);

    // Nominal byte
    clear_q();
    send_frame(8'hA5, 1'b1, e);
    idle(20);
    chk("nom_count", q_vt.size(), 1);
    if (q_vt.size() > 0) begin
      chk("nom_time", q_vt[0], e + LAT);
      chk("nom_byte", q_vb[0], 8'hA5);
    end
    chk("nom_ferr", q_ft.size(), 0);
    chk("nom_hold", o_rxbyte, 8'hA5);

    // Start glitch
    clear_q();
    i_rx = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", o_busy, 1'b1);
    idle(20);
    chk("glitch_busy_lo", o_busy, 1'b0);
    chk("glitch_valid", q_vt.size(), 0);
    chk("glitch_ferr", q_ft.size(), 0);
    chk("glitch_byte", o_rxbyte, 8'hA5);

    // Framing error followed by break
    clear_q();
    send_frame(8'h3C, 1'b0, e);
    repeat (200) @(negedge clk);
    chk("brk_ferr_count", q_ft.size(), 1);
    if (q_ft.size() > 0) chk("brk_ferr_time", q_ft[0], e + LAT);
    chk("brk_valid", q_vt.size(), 0);
    chk("brk_byte", o_rxbyte, 8'hA5);
    chk("brk_busy", o_busy, 1'b1);
    idle(20);
    chk("brk_release_busy", o_busy, 1'b0);
    chk("brk_no_retrig", q_ft.size(), 1);

    // Back-to-back frames
    clear_q();
    send_frame(8'h00, 1'b1, e);
    send_frame(8'hFF, 1'b1, e2);
    idle(20);
    chk("b2b_count", q_vt.size(), 2);
    if (q_vt.size() == 2) begin
      chk("b2b_t0", q_vt[0], e + LAT);
      chk("b2b_spacing", q_vt[1] - q_vt[0], 10 * BD);
      chk("b2b_byte0", q_vb[0], 8'h00);
      chk("b2b_byte1", q_vb[1], 8'hFF);
    end
    chk("b2b_ferr", q_ft.size(), 0);

    // Reset in the middle of data bit 4
    clear_q();
    b = 8'hC3;
    i_rx = 1'b0;
    repeat (BD) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      i_rx = b[k];
      repeat (BD) @(negedge clk);
    end
    i_rx = b[4];
    repeat (HF) @(negedge clk);
    chk("mid_busy_pre", o_busy, 1'b1);
    i_rst_n = 1'b0;
    i_rx    = 1'b1;
    @(negedge clk);
    chk("mid_rst_byte", o_rxbyte, 8'h00);
    chk("mid_rst_valid", o_rxvalid, 1'b0);
    chk("mid_rst_ferr", o_framing_err, 1'b0);
    chk("mid_rst_busy", o_busy, 1'b0);
    @(negedge clk);
    i_rst_n = 1'b1;
    idle(10);
    send_frame(8'h5A, 1'b1, e);
    idle(20);
    chk("mid_count", q_vt.size(), 1);
    if (q_vt.size() > 0) begin
      chk("mid_time", q_vt[0], e + LAT);
      chk("mid_byte", q_vb[0], 8'h5A);
    end
    chk("mid_ferr", q_ft.size(), 0);

    // Randomized frames with random gaps, some with bad stop bits
    clear_q();
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom_range(0, 255));
      stp = (i == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      send_frame(b, stp, e);
      if (stp) begin
        exp_vt.push_back(e + LAT);
        exp_vb.push_back(b);
        gap = $urandom_range(0, 30);
      end else begin
        exp_ft.push_back(e + LAT);
        gap = $urandom_range(2, 30);
      end
      idle(gap);
    end
    idle(30);
    chk("rnd_valid_count", q_vt.size(), exp_vt.size());
    chk("rnd_ferr_count", q_ft.size(), exp_ft.size());
    nmin = (q_vt.size() < exp_vt.size()) ? q_vt.size() : exp_vt.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("rnd_vtime%0d", i), q_vt[i], exp_vt[i]);
      chk($sformatf("rnd_vbyte%0d", i), q_vb[i], exp_vb[i]);
    end
    nmin = (q_ft.size() < exp_ft.size()) ? q_ft.size() : exp_ft.size();
    for (int i = 0; i < nmin; i++) begin
      chk($sformatf("rnd_ftime%0d", i), q_ft[i], exp_ft[i]);
    end

    chk("no_coincident_strobes", both_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
